// File: rtl/read_superpixel.sv
// ============================================================================
// Module   : read_superpixel
// Brief    : Scans one superpixel out of VGA RAM; returns top-left colour ID
//            and a flag telling whether every pixel matched it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_superpixel #(
    parameter int SPIXEL_X_WIDTH = 6,
    parameter int SPIXEL_Y_WIDTH = 6,
    parameter int SPIXEL_X_MAX   = 63,
    parameter int SPIXEL_Y_MAX   = 47,
    parameter int SP_SIZE        = 10,
    parameter int H_RES          = 640,
    parameter int VGA_ADDR_WIDTH = 19,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int RD_LAT         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SPIXEL_X_WIDTH-1:0] x,
    input  logic [SPIXEL_Y_WIDTH-1:0] y,
    input  logic                      ireq,
    output logic                      obusy,
    output logic                      odone,
    output logic [COLOR_ID_WIDTH-1:0] odata,
    output logic                      ouniform,
    output logic                      oerr,
    output logic [VGA_ADDR_WIDTH-1:0] oaddr,
    output logic                      ordreq,
    input  logic [COLOR_ID_WIDTH-1:0] irdata
);

    localparam int                      c_CNT_W    = $clog2(SP_SIZE);
    localparam logic [c_CNT_W-1:0]      c_LAST     = c_CNT_W'(SP_SIZE - 1);
    localparam logic [VGA_ADDR_WIDTH-1:0] c_STRIDE = VGA_ADDR_WIDTH'(H_RES);
    localparam logic [VGA_ADDR_WIDTH-1:0] c_ROW_STEP = VGA_ADDR_WIDTH'(SP_SIZE * H_RES);
    localparam logic [VGA_ADDR_WIDTH-1:0] c_COL_STEP = VGA_ADDR_WIDTH'(SP_SIZE);
    // Only the oldest read still in flight: the final return of a scan.
    localparam logic [RD_LAT-1:0]       c_SR_LAST  = RD_LAT'(1 << (RD_LAT - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [VGA_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [c_CNT_W-1:0]          col_q, col_d;
    logic [c_CNT_W-1:0]          row_q, row_d;
    logic [RD_LAT-1:0]           sr_q, sr_d;
    logic                        first_q, first_d;
    logic [COLOR_ID_WIDTH-1:0]   odata_q, odata_d;
    logic                        uni_q, uni_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;

    logic [VGA_ADDR_WIDTH-1:0]   w_base;
    logic                        w_oob;

    assign w_base = VGA_ADDR_WIDTH'(y) * c_ROW_STEP + VGA_ADDR_WIDTH'(x) * c_COL_STEP;
    assign w_oob  = (32'(x) > 32'(SPIXEL_X_MAX)) || (32'(y) > 32'(SPIXEL_Y_MAX));

    assign ordreq   = (state_q == S_ISSUE);
    assign oaddr    = ordreq ? (base_q + VGA_ADDR_WIDTH'(col_q)) : '0;
    assign obusy    = (state_q != S_IDLE);
    assign odone    = done_q;
    assign odata    = odata_q;
    assign ouniform = uni_q;
    assign oerr     = err_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        col_d   = col_q;
        row_d   = row_q;
        sr_d    = (sr_q << 1) | RD_LAT'(ordreq);
        first_d = first_q;
        odata_d = odata_q;
        uni_d   = uni_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (sr_q[RD_LAT-1]) begin
            if (first_q) begin
                odata_d = irdata;
                uni_d   = 1'b1;
                first_d = 1'b0;
            end else if (irdata != odata_q) begin
                uni_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ireq) begin
                    odata_d = '0;
                    uni_d   = 1'b0;
                    err_d   = w_oob;
                    first_d = 1'b1;
                    if (w_oob) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ISSUE;
                        base_d  = w_base;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (col_q == c_LAST) begin
                    col_d  = '0;
                    row_d  = row_q + c_CNT_W'(1);
                    base_d = base_q + c_STRIDE;
                    if (row_q == c_LAST) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    col_d = col_q + c_CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (sr_q == c_SR_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            sr_q    <= '0;
            first_q <= 1'b0;
            odata_q <= '0;
            uni_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sr_q    <= sr_d;
            first_q <= first_d;
            odata_q <= odata_d;
            uni_q   <= uni_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_read_superpixel.sv
// ============================================================================
// Module   : tb_read_superpixel
// Brief    : Scoreboard bench for read_superpixel with a 2-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_superpixel;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  x, y;
    logic        ireq;
    logic        obusy, odone, ouniform, oerr, ordreq;
    logic [7:0]  odata;
    logic [18:0] oaddr;
    logic [7:0]  irdata;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       e;
    } res_t;

    logic [18:0] exp_addr_q[$];
    res_t        exp_res_q[$];

    logic [7:0]  fill    = 8'h1C;
    int          special = -1;

    read_superpixel dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .ireq(ireq),
        .obusy(obusy), .odone(odone), .odata(odata), .ouniform(ouniform),
        .oerr(oerr), .oaddr(oaddr), .ordreq(ordreq), .irdata(irdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_val(input logic [18:0] a);
        return (int'(a) == special) ? 8'h03 : fill;
    endfunction

    // Two-cycle read RAM: data for the address of cycle C is on irdata in C+2.
    logic [18:0] p1_addr;
    always @(posedge clk) begin
        p1_addr <= oaddr;
        irdata  <= ram_val(p1_addr);
    end

    task automatic push_scan(input logic [5:0] sx, input logic [5:0] sy);
        res_t r;
        logic [18:0] a;
        r.d = ram_val(19'((sy * 10) * 640 + sx * 10));
        r.u = 1'b1;
        r.e = 1'b0;
        for (int rr = 0; rr < 10; rr++) begin
            for (int cc = 0; cc < 10; cc++) begin
                a = 19'((sy * 10 + rr) * 640 + sx * 10 + cc);
                exp_addr_q.push_back(a);
                if (ram_val(a) != r.d) r.u = 1'b0;
            end
        end
        exp_res_q.push_back(r);
    endtask

    task automatic scan(input logic [5:0] sx, input logic [5:0] sy,
                        input bit started, input bit mid_ireq, input bit b2b);
        int   n_req = 0;
        bit   done_seen = 0;
        res_t r;
        logic [18:0] ea;
        push_scan(sx, sy);
        if (!started) begin
            x = sx; y = sy; ireq = 1'b1;
        end
        for (int k = 1; k <= 150 && !done_seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ireq = 1'b0;
                checks++;
                if (obusy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_after_accept got=%b exp=1", obusy);
                end
            end
            if (mid_ireq && k == 50) begin
                x = 6'd9; y = 6'd9; ireq = 1'b1;
            end else if (mid_ireq && k == 51) begin
                ireq = 1'b0;
            end
            if (ordreq === 1'b1) begin
                n_req++;
                if (n_req == 1) begin
                    checks++;
                    if (k != 1) begin
                        failures++;
                        $display("FAIL first_req_cycle got=%0d exp=1", k);
                    end
                end
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL addr_extra got=%0d exp=none", oaddr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (oaddr !== ea) begin
                        failures++;
                        $display("FAIL addr got=%0d exp=%0d", oaddr, ea);
                    end
                end
            end
            if (odone === 1'b1) begin
                done_seen = 1;
                r = exp_res_q.pop_front();
                checks += 5;
                if (k != 103) begin
                    failures++;
                    $display("FAIL done_cycle got=%0d exp=103", k);
                end
                if (n_req != 100) begin
                    failures++;
                    $display("FAIL req_count got=%0d exp=100", n_req);
                end
                if ({odata, ouniform, oerr} !== {r.d, r.u, r.e}) begin
                    failures++;
                    $display("FAIL result got=%h/%b/%b exp=%h/%b/%b",
                             odata, ouniform, oerr, r.d, r.u, r.e);
                end
                if (obusy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done got=%b exp=0", obusy);
                end
                if (exp_addr_q.size() != 0) begin
                    failures++;
                    $display("FAIL addr_missing got=%0d exp=0", exp_addr_q.size());
                end
                if (b2b) begin
                    x = 6'd0; y = 6'd0; ireq = 1'b1;
                end
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=none exp=odone");
            exp_addr_q.delete();
            exp_res_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ireq = 1'b1; x = 6'd1; y = 6'd1;
        repeat (2) @(negedge clk);
        checks++;
        if ({obusy, odone, odata, ouniform, oerr, oaddr, ordreq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%h%b%b%h%b exp=0",
                     obusy, odone, odata, ouniform, oerr, oaddr, ordreq);
        end
        rst = 1'b0; ireq = 1'b0;
        @(negedge clk);
        checks++;
        if (obusy !== 1'b0 || ordreq !== 1'b0) begin
            failures++;
            $display("FAIL reset_ireq_ignored got=%b%b exp=00", obusy, ordreq);
        end
    endtask

    task automatic test_range;
        x = 6'd0; y = 6'd48; ireq = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) ireq = 1'b0;
            checks++;
            if (ordreq !== 1'b0) begin
                failures++;
                $display("FAIL range_no_req k=%0d got=%b exp=0", k, ordreq);
            end
            checks++;
            if (odone !== (k == 2)) begin
                failures++;
                $display("FAIL range_done k=%0d got=%b exp=%b", k, odone, k == 2);
            end
            if (k == 2) begin
                checks++;
                if ({oerr, odata, ouniform} !== {1'b1, 8'h00, 1'b0}) begin
                    failures++;
                    $display("FAIL range_result got=%b/%h/%b exp=1/00/0",
                             oerr, odata, ouniform);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        x = 6'd5; y = 6'd3; ireq = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) ireq = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ordreq !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_req got=%b exp=0", ordreq);
        end
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (odone === 1'b1 || ordreq === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_mid_quiet got=activity exp=none");
        end
    endtask

    initial begin
        rst = 1'b0; ireq = 1'b0; x = '0; y = '0;
        test_reset();
        fill = 8'h1C; special = -1;
        scan(6'd5, 6'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        special = 307199;
        scan(6'd63, 6'd47, 1'b0, 1'b0, 1'b1);
        scan(6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        test_range();
        special = 6410;
        test_reset_mid();
        scan(6'd1, 6'd1, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
